// File: rtl/pmd_selftest_if.sv
// PMD self-test handshake/bus bundle: test control, PMD data and result signals.
interface pmd_selftest_if;
  logic       start;
  logic       loopback;
  logic       tx_data;
  logic [1:0] rx_data;
  logic [1:0] rx_data_valid;
  logic       signal_status;
  logic       busy;
  logic       done;
  logic       pass;
  logic       fault;
  logic [7:0] err_count;

  modport master (
    output start, rx_data, rx_data_valid, signal_status,
    input  loopback, tx_data, busy, done, pass, fault, err_count
  );

  modport slave (
    input  start, rx_data, rx_data_valid, signal_status,
    output loopback, tx_data, busy, done, pass, fault, err_count
  );
endinterface

// File: rtl/pmd_selftest.sv
// PMD loopback self-test: transmits PRBS7, skips/primes/checks the looped-back
// stream with a self-synchronizing checker, reports pass/fault/error count.
module pmd_selftest #(
  parameter int CHECK_BITS  = 256,
  parameter int SKIP_BITS   = 8,
  parameter int SIG_TIMEOUT = 15,
  parameter int WATCHDOG    = 1023
) (
  input  logic          clk,
  input  logic          rst,
  pmd_selftest_if.slave bus
);
  localparam int SW = $clog2(SIG_TIMEOUT + 2);
  localparam int WW = $clog2(WATCHDOG + 1);

  typedef enum logic [2:0] {IDLE, WAIT_SIG, SKIP, LOAD, CHECK, FINISH} state_t;

  state_t        state, nxt, walk;
  logic [SW-1:0] sig_cnt;
  logic [WW-1:0] wd_cnt;
  logic [15:0]   bit_cnt, cnt_w;
  logic [6:0]    chk, chk_w, gen;
  logic [7:0]    err, err_w;
  logic          tx_q, fault_q, pass_q, abort, rb, fb;
  logic [1:0]    take;

  assign fb = gen[6] ^ gen[5];

  // Beat decode: take[0] = rx_data[1] valid, take[1] = rx_data[0] valid.
  always_comb begin
    case (bus.rx_data_valid)
      2'b01:   take = 2'b01;
      2'b10:   take = 2'b11;
      default: take = 2'b00;
    endcase
  end

  // Walk the beat bit by bit so a 2-bit beat can straddle SKIP/LOAD/CHECK or end CHECK early.
  always_comb begin
    walk  = state;
    cnt_w = bit_cnt;
    chk_w = chk;
    err_w = err;
    rb    = 1'b0;
    for (int i = 0; i < 2; i++) begin
      rb = bus.rx_data[~i[0]];
      if (take[i[0]]) begin
        case (walk)
          SKIP: begin
            if (cnt_w == 16'(SKIP_BITS - 1)) begin walk = LOAD; cnt_w = '0; end
            else cnt_w = cnt_w + 16'd1;
          end
          LOAD: begin
            chk_w = {chk_w[5:0], rb};
            if (cnt_w == 16'd6) begin walk = CHECK; cnt_w = '0; end
            else cnt_w = cnt_w + 16'd1;
          end
          CHECK: begin
            if ((rb != (chk_w[6] ^ chk_w[5])) && (err_w != 8'hFF)) err_w = err_w + 8'd1;
            chk_w = {chk_w[5:0], rb};
            if (cnt_w == 16'(CHECK_BITS - 1)) walk = FINISH;
            else cnt_w = cnt_w + 16'd1;
          end
          default: ;
        endcase
      end
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  // Next state: signal loss beats completion, completion beats the watchdog.
  always_comb begin
    nxt   = state;
    abort = 1'b0;
    case (state)
      IDLE:     if (bus.start) nxt = WAIT_SIG;
      WAIT_SIG: begin
        if (bus.signal_status) nxt = SKIP;
        else if (sig_cnt == SW'(SIG_TIMEOUT)) begin nxt = FINISH; abort = 1'b1; end
      end
      SKIP, LOAD, CHECK: begin
        if (!bus.signal_status) begin nxt = FINISH; abort = 1'b1; end
        else if (walk == FINISH) nxt = FINISH;
        else if (wd_cnt == WW'(WATCHDOG - 1)) begin nxt = FINISH; abort = 1'b1; end
        else nxt = walk;
      end
      default:  nxt = IDLE;
    endcase
  end

  // Outputs decoded from state; pass is live during FINISH and held afterwards.
  always_comb begin
    bus.busy     = (state != IDLE);
    bus.loopback = (state != IDLE);
    bus.done     = (state == FINISH);
    bus.pass     = pass_q | ((state == FINISH) & ~fault_q & (err == 8'd0));
  end

  assign bus.tx_data   = tx_q;
  assign bus.fault     = fault_q;
  assign bus.err_count = err;

  // Counters, checker register and results; a cycle with signal loss commits nothing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sig_cnt <= '0; wd_cnt <= '0; bit_cnt <= '0; chk <= '0;
      err <= '0; fault_q <= 1'b0; pass_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          sig_cnt <= '0; wd_cnt <= '0; bit_cnt <= '0; chk <= '0;
          err <= '0; fault_q <= 1'b0; pass_q <= 1'b0;
        end
        WAIT_SIG: begin
          sig_cnt <= sig_cnt + SW'(1);
          wd_cnt  <= '0;
          bit_cnt <= '0;
        end
        SKIP, LOAD, CHECK: if (bus.signal_status) begin
          wd_cnt  <= wd_cnt + WW'(1);
          bit_cnt <= cnt_w;
          chk     <= chk_w;
          err     <= err_w;
        end
        FINISH: pass_q <= ~fault_q & (err == 8'd0);
        default: ;
      endcase
      if (abort) fault_q <= 1'b1;
    end
  end

  // PRBS7 transmitter; tx is forced low whenever the next state is IDLE or FINISH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gen  <= '0;
      tx_q <= 1'b0;
    end else if ((state == IDLE) && bus.start) begin
      gen  <= 7'h7F;
      tx_q <= 1'b0;
    end else if (state inside {WAIT_SIG, SKIP, LOAD, CHECK}) begin
      gen  <= {gen[5:0], fb};
      tx_q <= (nxt inside {WAIT_SIG, SKIP, LOAD, CHECK}) & fb;
    end else begin
      tx_q <= 1'b0;
    end
  end
endmodule

// File: tb/tb_pmd_selftest.sv
// Self-checking bench for pmd_selftest: directed vector table, reset sequences,
// and randomized beats checked against a bit-stream reference model.
module tb_pmd_selftest;
  localparam int M_LOOP = 0, M_NOSIG = 1, M_NOVAL = 2, M_INV = 3, M_RAND = 4;
  localparam int SKIP = 8, CHKB = 256;

  typedef struct {
    string name; int mode; int flip; int drop;
    int exp_done; int exp_err; int exp_pass; int exp_fault;
  } vec_t;

  typedef struct {
    int dcyc; int e; int p; int f; int he; int hp; int hf;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  pmd_selftest_if bus();

  pmd_selftest dut (.clk(clk), .rst(rst), .bus(bus));

  always #4 clk = ~clk;

  int   checks = 0;
  int   failures = 0;
  bit   prbs [0:2047];
  bit   txh  [0:2047];
  bit   offered_q[$];
  int   offered_cyc[$];
  vec_t vecs [6];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: skip, prime 7, then count b[n] != b[n-7]^b[n-6] over CHECK_BITS bits.
  task automatic model(output int exp_err, output int exp_done);
    int need;
    need = SKIP + 7 + CHKB;
    exp_err = 0;
    exp_done = -1;
    if (offered_q.size() >= need) begin
      for (int n = SKIP + 7; n < need; n++)
        if (offered_q[n] != (offered_q[n-7] ^ offered_q[n-6]) && exp_err < 255) exp_err++;
      exp_done = offered_cyc[need-1] + 1;
    end
  endtask

  // One test run. Cycle k is the cycle after edge k-1 (cycle 0 carries start).
  task automatic run(input int mode, input int flip, input int drop, input int rst_at,
                     output res_t r);
    int j, off;
    logic [1:0] v;
    bit b0, b1;
    off = $urandom_range(0, 600);
    offered_q.delete();
    offered_cyc.delete();
    r = '{-1, 0, 0, 0, 0, 0, 0};
    j = 0;
    bus.start = 1'b1;
    bus.rx_data_valid = 2'b00;
    bus.signal_status = (mode != M_NOSIG);
    txh[0] = bus.tx_data;
    for (int k = 1; k <= 1400; k++) begin
      @(posedge clk); #1;
      bus.start = 1'b0;
      txh[k] = bus.tx_data;
      if (k == 1) begin
        chk("busy_after_start", bus.busy, 1);
        chk("loopback_after_start", bus.loopback, 1);
        chk("tx_in_wait_sig", bus.tx_data, 0);
      end
      if (bus.done) begin
        r.dcyc = k; r.e = bus.err_count; r.p = bus.pass; r.f = bus.fault;
        break;
      end
      if (k == rst_at) begin
        chk("pre_rst_err", bus.err_count, 2 * (k - 2) - 15);
        #1 rst = 1'b1;
        #1;
        chk("rst_loopback", bus.loopback, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_err", bus.err_count, 0);
        chk("rst_tx", bus.tx_data, 0);
        chk("rst_fault", bus.fault, 0);
        return;
      end
      bus.signal_status = (mode != M_NOSIG) && !(drop >= 0 && k >= drop);
      if (mode == M_RAND && k == 50) bus.start = 1'b1;
      v = 2'b00;
      b0 = 1'($urandom);
      b1 = 1'($urandom);
      case (mode)
        M_LOOP: if (k >= 2) begin
          v = 2'b01;
          b0 = ((k >= 3) ? txh[k-3] : 1'b0) ^ (j == flip);
        end
        M_INV: if (k >= 2) begin
          v = 2'b10;
          b0 = ~prbs[j];
          b1 = ~prbs[j+1];
        end
        M_RAND: begin
          v = 2'($urandom_range(0, 3));
          if (k >= 2) begin
            case ($urandom_range(0, 9))
              0, 1, 2, 3: v = 2'b01;
              4, 5, 6, 7: v = 2'b10;
              8:          v = 2'b00;
              default:    v = 2'b11;
            endcase
            b0 = prbs[off+j]   ^ ($urandom_range(0, 79) == 0);
            b1 = prbs[off+j+1] ^ ($urandom_range(0, 79) == 0);
          end
        end
        default: ;
      endcase
      bus.rx_data = {b0, b1};
      bus.rx_data_valid = v;
      if (k >= 2 && bus.signal_status) begin
        if (v == 2'b01) begin
          offered_q.push_back(b0); offered_cyc.push_back(k); j += 1;
        end else if (v == 2'b10) begin
          offered_q.push_back(b0); offered_cyc.push_back(k);
          offered_q.push_back(b1); offered_cyc.push_back(k); j += 2;
        end
      end
    end
    bus.rx_data_valid = 2'b00;
    @(posedge clk); #1;
    chk("busy_after_done", bus.busy, 0);
    chk("loopback_after_done", bus.loopback, 0);
    chk("done_one_cycle", bus.done, 0);
    chk("tx_idle_after_done", bus.tx_data, 0);
    r.he = bus.err_count; r.hp = bus.pass; r.hf = bus.fault;
  endtask

  task automatic cmp_res(input string nm, input res_t r, input int ed, input int ee,
                         input int ep, input int ef);
    chk({nm, "_done_cycle"}, r.dcyc, ed);
    chk({nm, "_err"}, r.e, ee);
    chk({nm, "_pass"}, r.p, ep);
    chk({nm, "_fault"}, r.f, ef);
    chk({nm, "_held_err"}, r.he, ee);
    chk({nm, "_held_pass"}, r.hp, ep);
    chk({nm, "_held_fault"}, r.hf, ef);
  endtask

  task automatic do_vec(input vec_t vv);
    res_t r;
    run(vv.mode, vv.flip, vv.drop, -1, r);
    cmp_res(vv.name, r, vv.exp_done, vv.exp_err, vv.exp_pass, vv.exp_fault);
  endtask

  initial begin
    bit   hist[$];
    int   bad, ee, ed;
    res_t r;

    // PRBS7 x^7+x^6+1 from an all-ones history: b[n] = b[n-7] ^ b[n-6].
    for (int n = 0; n < 7; n++) hist.push_back(1'b1);
    for (int n = 0; n < 2048; n++) begin
      prbs[n] = hist[hist.size()-7] ^ hist[hist.size()-6];
      hist.push_back(prbs[n]);
    end

    vecs[0] = '{"ideal",    M_LOOP,  -1,  -1,  273,   0, 1, 0};
    vecs[1] = '{"one_flip", M_LOOP,  100, -1,  273,   3, 0, 0};
    vecs[2] = '{"no_sig",   M_NOSIG, -1,  -1,  17,    0, 0, 1};
    vecs[3] = '{"watchdog", M_NOVAL, -1,  -1,  1025,  0, 0, 1};
    vecs[4] = '{"inverted", M_INV,   -1,  -1,  138, 255, 0, 0};
    vecs[5] = '{"sig_drop", M_LOOP,  -1,  100, 101,   0, 0, 1};

    bus.start = 1'b0;
    bus.rx_data = 2'b00;
    bus.rx_data_valid = 2'b00;
    bus.signal_status = 1'b0;

    // Reset state, then quiet idle after release.
    repeat (3) @(posedge clk);
    #1;
    chk("reset_loopback", bus.loopback, 0);
    chk("reset_tx", bus.tx_data, 0);
    chk("reset_busy", bus.busy, 0);
    chk("reset_done", bus.done, 0);
    chk("reset_pass", bus.pass, 0);
    chk("reset_fault", bus.fault, 0);
    chk("reset_err", bus.err_count, 0);
    rst = 1'b0;
    bus.signal_status = 1'b1;
    bad = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (bus.busy || bus.loopback || bus.tx_data || bus.done) bad++;
    end
    chk("idle_no_activity", bad, 0);

    // Directed vector table.
    for (int i = 0; i < 6; i++) begin
      do_vec(vecs[i]);
      if (i == 0) begin
        bad = 0;
        for (int k = 2; k <= 272; k++) if (txh[k] != prbs[k-2]) bad++;
        chk("tx_prbs_seq", bad, 0);
        chk("tx_zero_in_finish", txh[273], 0);
      end
    end

    // Reset mid-CHECK, then a clean run must pass.
    run(M_INV, -1, -1, 60, r);
    @(posedge clk); #1;
    rst = 1'b0;
    bus.rx_data_valid = 2'b00;
    bad = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (bus.busy || bus.loopback) bad++;
    end
    chk("idle_after_rst", bad, 0);
    do_vec(vecs[0]);

    // Randomized beats (00/01/10/11, flips, ignored start) against the model.
    for (int it = 0; it < 6; it++) begin
      run(M_RAND, -1, -1, -1, r);
      model(ee, ed);
      cmp_res($sformatf("rand%0d", it), r, ed, ee, (ee == 0) ? 1 : 0, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
